// File: rtl/chirp_sweep_sequencer_if.sv
// Handshake/config/output bundle between a sweep controller and the chirp sequencer.
interface chirp_sweep_sequencer_if #(
  parameter int FW = 16,
  parameter int CW = 8,
  parameter int DW = 8
);
  logic          start;
  logic          abort;
  logic [FW-1:0] cfg_f0;
  logic [FW-1:0] cfg_f1;
  logic [FW-1:0] cfg_step;
  logic [DW-1:0] cfg_dwell;
  logic [DW-1:0] cfg_gap;
  logic [CW-1:0] cfg_nchirp;
  logic [FW-1:0] freq_word;
  logic          freq_valid;
  logic          chirp_sync;
  logic [CW-1:0] chirp_idx;
  logic          busy;
  logic          done;

  modport master (
    output start, abort, cfg_f0, cfg_f1, cfg_step, cfg_dwell, cfg_gap, cfg_nchirp,
    input  freq_word, freq_valid, chirp_sync, chirp_idx, busy, done
  );

  modport slave (
    input  start, abort, cfg_f0, cfg_f1, cfg_step, cfg_dwell, cfg_gap, cfg_nchirp,
    output freq_word, freq_valid, chirp_sync, chirp_idx, busy, done
  );
endinterface

// File: rtl/chirp_sweep_sequencer.sv
// Stepped-frequency chirp sequencer: sole writer of the NCO frequency word.
//
//   state   | meaning
//   --------+------------------------------------------------------------
//   S_IDLE  | waiting for start; all outputs 0 except a possible done pulse
//   S_SWEEP | driving freq_word, stepping every dwell+1 cycles
//   S_GAP   | quiet interval of cfg_gap cycles between chirps
module chirp_sweep_sequencer #(
  parameter int FW = 16,
  parameter int CW = 8,
  parameter int DW = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  chirp_sweep_sequencer_if.slave  bus
);

  typedef enum logic [1:0] {S_IDLE, S_SWEEP, S_GAP} state_t;

  state_t        state;
  logic [FW-1:0] f0_q, f1_q, step_q;
  logic [DW-1:0] dwell_q, gap_q;
  logic [CW-1:0] nchirp_q;
  logic [DW-1:0] dwell_cnt, gap_cnt;
  logic [FW-1:0] freq_q;
  logic          valid_q, sync_q, busy_q, done_q;
  logic [CW-1:0] idx_q;

  logic [FW:0]   next_freq;
  logic          chirp_end;
  logic          last_chirp;

  // One extra bit so a carry out of the add counts as passing f1.
  assign next_freq  = {1'b0, freq_q} + {1'b0, step_q};
  assign chirp_end  = (step_q == '0) || (next_freq > {1'b0, f1_q});
  assign last_chirp = (nchirp_q != '0) && (idx_q == nchirp_q - CW'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      f0_q      <= '0;
      f1_q      <= '0;
      step_q    <= '0;
      dwell_q   <= '0;
      gap_q     <= '0;
      nchirp_q  <= '0;
      dwell_cnt <= '0;
      gap_cnt   <= '0;
      freq_q    <= '0;
      valid_q   <= 1'b0;
      sync_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      idx_q     <= '0;
    end else begin
      sync_q <= 1'b0;
      done_q <= 1'b0;
      if (bus.abort) begin
        state   <= S_IDLE;
        freq_q  <= '0;
        valid_q <= 1'b0;
        busy_q  <= 1'b0;
        idx_q   <= '0;
      end else begin
        case (state)
          S_IDLE: begin
            if (bus.start) begin
              f0_q      <= bus.cfg_f0;
              f1_q      <= bus.cfg_f1;
              step_q    <= bus.cfg_step;
              dwell_q   <= bus.cfg_dwell;
              gap_q     <= bus.cfg_gap;
              nchirp_q  <= bus.cfg_nchirp;
              dwell_cnt <= bus.cfg_dwell;
              freq_q    <= bus.cfg_f0;
              valid_q   <= 1'b1;
              sync_q    <= 1'b1;
              busy_q    <= 1'b1;
              idx_q     <= '0;
              state     <= S_SWEEP;
            end
          end
          S_SWEEP: begin
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - DW'(1);
            end else if (!chirp_end) begin
              freq_q    <= next_freq[FW-1:0];
              dwell_cnt <= dwell_q;
            end else if (last_chirp) begin
              state   <= S_IDLE;
              freq_q  <= '0;
              valid_q <= 1'b0;
              busy_q  <= 1'b0;
              done_q  <= 1'b1;
              idx_q   <= '0;
            end else if (gap_q != '0) begin
              state   <= S_GAP;
              freq_q  <= '0;
              valid_q <= 1'b0;
              gap_cnt <= gap_q - DW'(1);
            end else begin
              freq_q    <= f0_q;
              sync_q    <= 1'b1;
              dwell_cnt <= dwell_q;
              idx_q     <= idx_q + CW'(1);
            end
          end
          S_GAP: begin
            if (gap_cnt != '0) begin
              gap_cnt <= gap_cnt - DW'(1);
            end else begin
              state     <= S_SWEEP;
              freq_q    <= f0_q;
              valid_q   <= 1'b1;
              sync_q    <= 1'b1;
              dwell_cnt <= dwell_q;
              idx_q     <= idx_q + CW'(1);
            end
          end
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign bus.freq_word  = freq_q;
  assign bus.freq_valid = valid_q;
  assign bus.chirp_sync = sync_q;
  assign bus.chirp_idx  = idx_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;

endmodule
